// File: rtl/imm_gen_pipe_if.sv
// Producer/consumer bundle for imm_gen_pipe: instruction push side, immediate pop side,
// flush and occupancy. Producer and consumer share the master modport; the generator is the slave.
interface imm_gen_pipe_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2,
  parameter int TAG_W = 4
);
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic             Flush;
  logic             InValid;
  logic             InReady;
  logic [31:0]      Instr;
  logic [2:0]       ImmControl;
  logic [TAG_W-1:0] InTag;
  logic             OutValid;
  logic             OutReady;
  logic [XLEN-1:0]  ExtendedImm;
  logic             ImmErr;
  logic [TAG_W-1:0] OutTag;
  logic [OCC_W-1:0] Occupancy;

  modport master (
    output Flush, InValid, Instr, ImmControl, InTag, OutReady,
    input  InReady, OutValid, ExtendedImm, ImmErr, OutTag, Occupancy
  );

  modport slave (
    input  Flush, InValid, Instr, ImmControl, InTag, OutReady,
    output InReady, OutValid, ExtendedImm, ImmErr, OutTag, Occupancy
  );
endinterface

// File: rtl/imm_gen_pipe.sv
// Pipelined RISC-V immediate generator: extends at push, queues {imm, err, tag} in DEPTH entries.
// One-cycle latency when empty; InReady depends only on occupancy, so a full queue never passes through.
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2,
  parameter int TAG_W = 4
) (
  input logic          CLK,
  input logic          RST_n,
  imm_gen_pipe_if.slave bus
);
  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic             err;
    logic [TAG_W-1:0] tag;
  } entry_t;

  entry_t           mem [DEPTH];
  entry_t           in_ent;
  entry_t           head;
  logic [XLEN-1:0]  imm_c;
  logic             err_c;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [OCC_W-1:0] count;
  logic             push;
  logic             pop;
  logic             unused_opcode;

  // Opcode bits never carry immediate data.
  assign unused_opcode = ^bus.Instr[6:0];

  always_comb begin
    imm_c = '0;
    err_c = 1'b0;
    case (bus.ImmControl)
      3'b000: imm_c = XLEN'($signed(bus.Instr[31:20]));
      3'b001: imm_c = XLEN'($signed({bus.Instr[31:25], bus.Instr[11:7]}));
      3'b010: imm_c = XLEN'($signed({bus.Instr[31], bus.Instr[7], bus.Instr[30:25],
                                      bus.Instr[11:8], 1'b0}));
      3'b011: imm_c = XLEN'($signed({bus.Instr[31], bus.Instr[19:12], bus.Instr[20],
                                      bus.Instr[30:21], 1'b0}));
      3'b100: imm_c = XLEN'($signed({bus.Instr[31:12], 12'h000}));
      3'b101: imm_c = XLEN'(bus.Instr[19:15]);
      3'b110: imm_c = (XLEN == 64) ? XLEN'(bus.Instr[25:20]) : XLEN'(bus.Instr[24:20]);
      default: err_c = 1'b1;
    endcase
  end

  assign in_ent = '{imm: imm_c, err: err_c, tag: bus.InTag};

  // Explicit wrap keeps non-power-of-two depths correct.
  function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign bus.InReady  = (count != OCC_W'(DEPTH));
  assign bus.OutValid = (count != '0);
  assign push         = bus.InValid & bus.InReady;
  assign pop          = bus.OutValid & bus.OutReady;

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (bus.Flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= bump(wr_ptr);
      if (pop)  rd_ptr <= bump(rd_ptr);
      if (push && !pop)      count <= count + OCC_W'(1);
      else if (pop && !push) count <= count - OCC_W'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (push && !bus.Flush) mem[wr_ptr] <= in_ent;
  end

  assign head            = bus.OutValid ? mem[rd_ptr] : '0;
  assign bus.ExtendedImm = head.imm;
  assign bus.ImmErr      = head.err;
  assign bus.OutTag      = head.tag;
  assign bus.Occupancy   = count;
endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: a 32-bit/DEPTH=2 and a 64-bit/DEPTH=3 instance checked every
// cycle against a queue model, plus literal expectations at key points.
module tb_imm_gen_pipe;
  logic CLK;
  logic RST_n;

  imm_gen_pipe_if #(.XLEN(32), .DEPTH(2), .TAG_W(4)) b0();
  imm_gen_pipe_if #(.XLEN(64), .DEPTH(3), .TAG_W(4)) b1();

  imm_gen_pipe #(.XLEN(32), .DEPTH(2), .TAG_W(4)) dut0 (.CLK(CLK), .RST_n(RST_n), .bus(b0));
  imm_gen_pipe #(.XLEN(64), .DEPTH(3), .TAG_W(4)) dut1 (.CLK(CLK), .RST_n(RST_n), .bus(b1));

  typedef struct packed {
    logic [63:0] imm;
    logic        err;
    logic [3:0]  tag;
  } ent_t;

  ent_t q0[$];
  ent_t q1[$];
  ent_t e0, e1;
  int   tests = 0;
  int   fails = 0;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Immediate value straight from the field layout of each instruction format.
  function automatic logic [63:0] ref_imm(input logic [31:0] w, input logic [2:0] c, input int xl);
    logic [63:0] r;
    r = '0;
    case (c)
      3'd0: r = 64'($signed(w[31:20]));
      3'd1: r = 64'($signed({w[31:25], w[11:7]}));
      3'd2: r = 64'($signed({w[31], w[7], w[30:25], w[11:8], 1'b0}));
      3'd3: r = 64'($signed({w[31], w[19:12], w[20], w[30:21], 1'b0}));
      3'd4: r = 64'($signed({w[31:12], 12'h000}));
      3'd5: r = {59'd0, w[19:15]};
      3'd6: r = (xl == 64) ? {58'd0, w[25:20]} : {59'd0, w[24:20]};
      default: r = '0;
    endcase
    if (xl == 32) r[63:32] = '0;
    return r;
  endfunction

  function automatic ent_t mk(input logic [31:0] w, input logic [2:0] c, input logic [3:0] t,
                              input int xl);
    ent_t e;
    e.imm = ref_imm(w, c, xl);
    e.err = (c == 3'd7);
    e.tag = t;
    return e;
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge CLK or negedge RST_n) begin
    if (!RST_n || b0.Flush) begin
      q0.delete();
    end else begin
      bit do_push;
      do_push = b0.InValid && (q0.size() < 2);
      if (b0.OutReady && q0.size() > 0) void'(q0.pop_front());
      if (do_push) q0.push_back(mk(b0.Instr, b0.ImmControl, b0.InTag, 32));
    end
  end

  always @(posedge CLK or negedge RST_n) begin
    if (!RST_n || b1.Flush) begin
      q1.delete();
    end else begin
      bit do_push;
      do_push = b1.InValid && (q1.size() < 3);
      if (b1.OutReady && q1.size() > 0) void'(q1.pop_front());
      if (do_push) q1.push_back(mk(b1.Instr, b1.ImmControl, b1.InTag, 64));
    end
  end

  always @(negedge CLK) begin
    e0 = (q0.size() != 0) ? q0[0] : '0;
    e1 = (q1.size() != 0) ? q1[0] : '0;
    check("d0_out_valid", 64'(b0.OutValid),    64'(q0.size() != 0));
    check("d0_in_ready",  64'(b0.InReady),     64'(q0.size() < 2));
    check("d0_occupancy", 64'(b0.Occupancy),   64'(q0.size()));
    check("d0_imm",       64'(b0.ExtendedImm), e0.imm);
    check("d0_err",       64'(b0.ImmErr),      64'(e0.err));
    check("d0_tag",       64'(b0.OutTag),      64'(e0.tag));
    check("d1_out_valid", 64'(b1.OutValid),    64'(q1.size() != 0));
    check("d1_in_ready",  64'(b1.InReady),     64'(q1.size() < 3));
    check("d1_occupancy", 64'(b1.Occupancy),   64'(q1.size()));
    check("d1_imm",       b1.ExtendedImm,      e1.imm);
    check("d1_err",       64'(b1.ImmErr),      64'(e1.err));
    check("d1_tag",       64'(b1.OutTag),      64'(e1.tag));
  end

  task automatic push(input int sel, input logic [31:0] w, input logic [2:0] c, input logic [3:0] t);
    bit ok;
    ok = 1'b0;
    if (sel == 0) begin
      b0.InValid = 1'b1; b0.Instr = w; b0.ImmControl = c; b0.InTag = t;
    end else begin
      b1.InValid = 1'b1; b1.Instr = w; b1.ImmControl = c; b1.InTag = t;
    end
    for (int k = 0; k < 40 && !ok; k++) begin
      @(negedge CLK);
      ok = (sel == 0) ? b0.InReady : b1.InReady;
    end
    check("push_accept_within_bound", 64'(ok), 64'd1);
    @(posedge CLK);
    #1;
    b0.InValid = 1'b0;
    b1.InValid = 1'b0;
  endtask

  // Hand-derived 32-bit vectors: I, S, B, U, J, Z, SHAMT.
  logic [31:0] t1_w   [7] = '{32'hFFF0F0F0, 32'h00F0F0F0, 32'h0F0F0F0F, 32'h12345000,
                              32'hFEDCBA98, 32'h000FD073, 32'h03F01013};
  logic [2:0]  t1_c   [7] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd3, 3'd5, 3'd6};
  logic [31:0] t1_exp [7] = '{32'hFFFFFFFF, 32'h00000001, 32'h000000FE, 32'h12345000,
                              32'hFFFCBFEC, 32'h0000001F, 32'h0000001F};

  initial begin
    RST_n = 1'b0;
    b0.Flush = 0; b0.InValid = 0; b0.Instr = '0; b0.ImmControl = '0; b0.InTag = '0; b0.OutReady = 0;
    b1.Flush = 0; b1.InValid = 0; b1.Instr = '0; b1.ImmControl = '0; b1.InTag = '0; b1.OutReady = 1;
    #2;
    check("rst_out_valid", 64'(b0.OutValid),    64'd0);
    check("rst_in_ready",  64'(b0.InReady),     64'd1);
    check("rst_occupancy", 64'(b0.Occupancy),   64'd0);
    check("rst_imm",       64'(b0.ExtendedImm), 64'd0);
    check("rst_err_tag",   64'({b0.ImmErr, b0.OutTag}), 64'd0);
    check("rst_d1_ready",  64'(b1.InReady),     64'd1);
    repeat (2) @(posedge CLK);
    #1 RST_n = 1'b1;

    b0.OutReady = 1'b1;
    for (int i = 0; i < 7; i++) begin
      push(0, t1_w[i], t1_c[i], 4'(i));
      check("t1_imm", 64'(b0.ExtendedImm), 64'(t1_exp[i]));
      check("t1_err", 64'(b0.ImmErr), 64'd0);
      check("t1_occ", 64'(b0.Occupancy), 64'd1);
    end
    @(posedge CLK); #1;

    push(1, 32'h80000037, 3'd4, 4'd1);
    check("t2_u64", b1.ExtendedImm, 64'hFFFFFFFF80000000);
    push(1, 32'h03F01013, 3'd6, 4'd2);
    check("t2_shamt64", b1.ExtendedImm, 64'h000000000000003F);
    push(1, 32'h000FD073, 3'd5, 4'd3);
    check("t2_zimm64", b1.ExtendedImm, 64'h000000000000001F);
    push(1, 32'hFFF0F0F0, 3'd0, 4'd4);
    check("t2_i64", b1.ExtendedImm, 64'hFFFFFFFFFFFFFFFF);

    push(0, 32'h12345678, 3'd7, 4'd5);
    check("t3_imm", 64'(b0.ExtendedImm), 64'd0);
    check("t3_err", 64'(b0.ImmErr), 64'd1);
    check("t3_tag", 64'(b0.OutTag), 64'd5);
    push(0, 32'h00100000, 3'd0, 4'd6);
    check("t3_err_clear", 64'(b0.ImmErr), 64'd0);
    check("t3_next_imm", 64'(b0.ExtendedImm), 64'd1);
    @(posedge CLK); #1;

    b0.OutReady = 1'b0;
    push(0, 32'h00A00000, 3'd0, 4'd1);
    push(0, 32'h00B00000, 3'd0, 4'd2);
    check("t4_full_ready", 64'(b0.InReady), 64'd0);
    check("t4_full_occ", 64'(b0.Occupancy), 64'd2);
    b0.InValid = 1'b1; b0.Instr = 32'h00C00000; b0.ImmControl = 3'd0; b0.InTag = 4'd3;
    repeat (2) @(posedge CLK);
    #1;
    check("t4_held_occ", 64'(b0.Occupancy), 64'd2);
    check("t4_held_head", 64'(b0.ExtendedImm), 64'hA);
    b0.OutReady = 1'b1;
    @(posedge CLK); #1;
    check("t4_pop_when_full_occ", 64'(b0.Occupancy), 64'd1);
    check("t4_second_head", 64'(b0.ExtendedImm), 64'hB);
    @(posedge CLK); #1;
    check("t4_third_accepted", 64'(b0.ExtendedImm), 64'hC);
    check("t4_third_tag", 64'(b0.OutTag), 64'd3);
    b0.InValid = 1'b0;
    @(posedge CLK); #1;
    check("t4_drained", 64'(b0.Occupancy), 64'd0);

    b0.OutReady = 1'b0;
    push(0, 32'h01000000, 3'd0, 4'd0);
    b0.OutReady = 1'b1;
    for (int k = 0; k < 5; k++) begin
      push(0, {12'(k * 3 + 1), 20'h0}, 3'd0, 4'(k));
      check("t5_occ", 64'(b0.Occupancy), 64'd1);
      check("t5_head", 64'(b0.ExtendedImm), 64'(k * 3 + 1));
    end
    b1.OutReady = 1'b0;
    push(1, 32'h00700000, 3'd0, 4'd7);
    push(1, 32'h00800000, 3'd0, 4'd8);
    b1.OutReady = 1'b1;
    for (int k = 0; k < 5; k++) push(1, {12'(k + 9), 20'h0}, 3'd0, 4'(k + 9));
    check("t5_d1_occ", 64'(b1.Occupancy), 64'd2);
    check("t5_d1_head", b1.ExtendedImm, 64'd12);
    @(posedge CLK); #1;

    b0.OutReady = 1'b0;
    push(0, 32'h05500000, 3'd0, 4'd1);
    push(0, 32'h06600000, 3'd0, 4'd2);
    check("t6_pre_occ", 64'(b0.Occupancy), 64'd2);
    b0.Flush = 1'b1; b0.InValid = 1'b1; b0.Instr = 32'h09900000; b0.OutReady = 1'b1;
    @(posedge CLK); #1;
    b0.Flush = 1'b0; b0.InValid = 1'b0;
    check("t6_flush_occ", 64'(b0.Occupancy), 64'd0);
    check("t6_flush_valid", 64'(b0.OutValid), 64'd0);
    check("t6_flush_ready", 64'(b0.InReady), 64'd1);
    check("t6_flush_imm", 64'(b0.ExtendedImm), 64'd0);
    b0.OutReady = 1'b0;
    push(0, 32'h07700000, 3'd0, 4'd3);
    push(0, 32'h08800000, 3'd0, 4'd4);
    b0.OutReady = 1'b1;
    @(posedge CLK); #1;
    check("t6_draining_head", 64'(b0.ExtendedImm), 64'h88);
    #1 RST_n = 1'b0;
    #1;
    check("t6_arst_valid", 64'(b0.OutValid), 64'd0);
    check("t6_arst_imm", 64'(b0.ExtendedImm), 64'd0);
    check("t6_arst_tag", 64'(b0.OutTag), 64'd0);
    check("t6_arst_occ", 64'(b0.Occupancy), 64'd0);
    check("t6_arst_ready", 64'(b0.InReady), 64'd1);
    @(posedge CLK); #1 RST_n = 1'b1;
    push(0, 32'h00500000, 3'd0, 4'd9);
    check("t6_post_rst_imm", 64'(b0.ExtendedImm), 64'd5);
    check("t6_post_rst_tag", 64'(b0.OutTag), 64'd9);
    repeat (3) @(posedge CLK);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
